// File: rtl/ftc_pkg.sv
// rtl/ftc_pkg.sv - FTC code table, widths and codeword decode helper
// Shared by the receive-side decoder and the transmit-side encoder.

package ftc_pkg;

    localparam int unsigned CW_W = 4;   // codeword width
    localparam int unsigned DW_W = 3;   // data bits carried per codeword

    // Index is the 3-bit data value, entry is its codeword.
    localparam logic [CW_W-1:0] FTC_CODE [0:7] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1000, 4'b1100, 4'b1110, 4'b1111
    };

    typedef struct packed {
        logic            err;
        logic [DW_W-1:0] data;
    } ftc_dec_t;

    // Codewords not in the table (even FTC-legal ones like 0110/1001)
    // decode to 000 with err set.
    function automatic ftc_dec_t ftc_decode(input logic [CW_W-1:0] cw);
        ftc_dec_t r;
        r = '{err: 1'b1, data: '0};
        for (int i = 0; i < 8; i++) begin
            if (cw == FTC_CODE[i]) begin
                r = '{err: 1'b0, data: DW_W'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [CW_W-1:0] ftc_encode(input logic [DW_W-1:0] data);
        return FTC_CODE[data];
    endfunction

endpackage

// File: rtl/ftc_grp_dec.sv
// rtl/ftc_grp_dec.sv - combinational decode of one 4-bit FTC codeword group
// Ports: cw   - received codeword
//        data - decoded 3-bit value (000 when invalid)
//        err  - codeword is not in the code table

module ftc_grp_dec
    import ftc_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output logic [DW_W-1:0] data,
    output logic            err
);

    ftc_dec_t dec;

    assign dec  = ftc_decode(cw);
    assign data = dec.data;
    assign err  = dec.err;

endmodule

// File: rtl/ftc_dec_pipe.sv
// rtl/ftc_dec_pipe.sv - flow-controlled FTC bus decoder with skid buffer and error counter
// Ports: clk, rst (sync, active high)
//        in_data/in_valid/in_ready     - received codeword bus, group g at [4g+3:4g]
//        out_data/out_err_grp/out_err  - decoded word, per-group invalid flags, their OR
//        out_valid/out_ready           - output handshake
//        err_clr/err_cnt               - saturating count of accepted words with errors

module ftc_dec_pipe
    import ftc_pkg::*;
#(
    parameter int unsigned N_GRP  = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_GRP-1:0]    in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [N_GRP-1:0]      out_err_grp,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int unsigned FULL_W = DW_W * N_GRP;

    generate
        if (DATA_W > FULL_W) begin : g_bad_width
            $error("ftc_dec_pipe: DATA_W must not exceed 3*N_GRP");
        end
    endgenerate

    logic [FULL_W-1:0] dec_full;
    logic [N_GRP-1:0]  dec_err;
    logic [DATA_W-1:0] dec_data;

    generate
        for (genvar g = 0; g < N_GRP; g++) begin : g_grp
            ftc_grp_dec u_grp_dec (
                .cw   (in_data[CW_W*g +: CW_W]),
                .data (dec_full[DW_W*g +: DW_W]),
                .err  (dec_err[g])
            );
        end
    endgenerate

    assign dec_data = dec_full[DATA_W-1:0];

    // High decoded bits beyond DATA_W are discarded on purpose.
    generate
        if (DATA_W < FULL_W) begin : g_drop
            logic [FULL_W-DATA_W-1:0] drop_unused;
            assign drop_unused = dec_full[FULL_W-1:DATA_W];
        end
    endgenerate

    logic              accept;
    logic              drain;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [N_GRP-1:0]  skid_err_grp;

    logic              out_valid_n;
    logic [DATA_W-1:0] out_data_n;
    logic [N_GRP-1:0]  out_err_grp_n;
    logic              skid_valid_n;
    logic [DATA_W-1:0] skid_data_n;
    logic [N_GRP-1:0]  skid_err_grp_n;

    assign accept  = in_valid && in_ready;
    assign drain   = out_valid && out_ready;
    assign out_err = |out_err_grp;

    // The skid only fills while the main register is held, so when the
    // skid is full in_ready is low and no accept can collide with the
    // skid-to-main move.
    always_comb begin
        out_valid_n    = out_valid;
        out_data_n     = out_data;
        out_err_grp_n  = out_err_grp;
        skid_valid_n   = skid_valid;
        skid_data_n    = skid_data;
        skid_err_grp_n = skid_err_grp;

        if (drain) begin
            out_valid_n  = skid_valid;
            skid_valid_n = 1'b0;
            if (skid_valid) begin
                out_data_n    = skid_data;
                out_err_grp_n = skid_err_grp;
            end
        end

        if (accept) begin
            if (!out_valid_n) begin
                out_valid_n   = 1'b1;
                out_data_n    = dec_data;
                out_err_grp_n = dec_err;
            end else begin
                skid_valid_n   = 1'b1;
                skid_data_n    = dec_data;
                skid_err_grp_n = dec_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_err_grp  <= '0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            skid_err_grp <= '0;
            in_ready     <= 1'b1;
        end else begin
            out_valid    <= out_valid_n;
            out_data     <= out_data_n;
            out_err_grp  <= out_err_grp_n;
            skid_valid   <= skid_valid_n;
            skid_data    <= skid_data_n;
            skid_err_grp <= skid_err_grp_n;
            in_ready     <= !skid_valid_n;
        end
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if (accept && (|dec_err) && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
